// File: rtl/wb_trace_buffer_if.sv
// Write-back debug capture and trace drain signals of wb_trace_buffer; the slave modport is the buffer side.
interface wb_trace_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   debug_wb_pc;
  logic [3:0]    debug_wb_rf_we;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;

  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_pc;
  logic [4:0]    trace_wnum;
  logic [31:0]   trace_wdata;
  logic [CW-1:0] trace_count;
  logic          trace_overflow;
  logic [15:0]   trace_drop_cnt;

  modport master (
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ready,
    input  trace_valid, trace_pc, trace_wnum, trace_wdata, trace_count,
           trace_overflow, trace_drop_cnt
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ready,
    output trace_valid, trace_pc, trace_wnum, trace_wdata, trace_count,
           trace_overflow, trace_drop_cnt
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Retired-instruction trace FIFO: captures qualifying WB register writes, visible one cycle later.
// Never stalls the CPU; when full (and not popping) the record is dropped and counted instead.
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter bit FILTER_R0 = 1'b1
) (
  input logic              clk,
  input logic              resetn,
  input logic              clear,
  wb_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        rec;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [31:0]   mdata;
  logic          cap;
  logic          full;
  logic          valid;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    mdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.debug_wb_rf_we[i]) mdata[8*i +: 8] = bus.debug_wb_rf_wdata[8*i +: 8];
    end
  end

  assign rec   = '{pc: bus.debug_wb_pc, wnum: bus.debug_wb_rf_wnum, wdata: mdata};
  assign cap   = (bus.debug_wb_rf_we != 4'h0) && (!FILTER_R0 || (bus.debug_wb_rf_wnum != 5'd0));
  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);
  assign pop   = valid && bus.trace_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push  = cap && (!full || pop);
  assign drop  = cap && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Storage is left unreset; it is only observable through the count-gated head mux.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= rec;
  end

  assign head = mem[rd_ptr];

  assign bus.trace_valid    = valid;
  assign bus.trace_pc       = valid ? head.pc    : 32'h0;
  assign bus.trace_wnum     = valid ? head.wnum  : 5'h0;
  assign bus.trace_wdata    = valid ? head.wdata : 32'h0;
  assign bus.trace_count    = count;
  assign bus.trace_overflow = overflow;
  assign bus.trace_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer against a queue-based model of the trace FIFO.
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;

  logic clk;
  logic resetn;
  logic clear;
  int   total;
  int   bad;

  wb_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

  wb_trace_buffer #(.DEPTH(DEPTH), .FILTER_R0(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_ov;
  logic [15:0] m_drop;

  // Apply the model for the upcoming edge using the currently driven inputs, then advance.
  task automatic cycle();
    ent_t e;
    bit   cap;
    cap = (bus.debug_wb_rf_we != 4'h0) && (bus.debug_wb_rf_wnum != 5'd0);
    if (clear) begin
      q.delete();
      m_ov   = 1'b0;
      m_drop = 16'h0;
    end else begin
      if (bus.trace_ready && q.size() > 0) e = q.pop_front();
      if (cap) begin
        if (q.size() < DEPTH) begin
          e.pc   = bus.debug_wb_pc;
          e.wnum = bus.debug_wb_rf_wnum;
          e.data = 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.debug_wb_rf_we[b]) e.data[8*b +: 8] = bus.debug_wb_rf_wdata[8*b +: 8];
          q.push_back(e);
        end else begin
          m_ov = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.debug_wb_rf_we = 4'h0;
    bus.trace_ready    = 1'b0;
    clear              = 1'b0;
  endtask

  task automatic capture(input logic [31:0] pc, input logic [3:0] we,
                         input logic [4:0] wnum, input logic [31:0] wdata);
    bus.debug_wb_pc       = pc;
    bus.debug_wb_rf_we    = we;
    bus.debug_wb_rf_wnum  = wnum;
    bus.debug_wb_rf_wdata = wdata;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.trace_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.trace_valid); end
    total++; if (bus.trace_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.trace_count); end
    total++; if (bus.trace_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.trace_overflow); end
    total++; if (bus.trace_drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_drop got=%h exp=0", bus.trace_drop_cnt); end
    total++; if ({bus.trace_pc, bus.trace_wnum, bus.trace_wdata} !== 69'h0) begin
      bad++; $display("FAIL reset_head got=%h/%h/%h exp=0", bus.trace_pc, bus.trace_wnum, bus.trace_wdata);
    end
  endtask

  task automatic test_basic();
    idle();
    capture(32'h1c000000, 4'hf, 5'd5, 32'h12345678);
    cycle();
    idle();
    total++; if (bus.trace_valid !== 1'b1 || bus.trace_count !== 5'd1) begin
      bad++; $display("FAIL basic_valid got=%b cnt=%0d exp=1 cnt=1", bus.trace_valid, bus.trace_count);
    end
    total++; if ({bus.trace_pc, bus.trace_wnum, bus.trace_wdata} !== {32'h1c000000, 5'd5, 32'h12345678}) begin
      bad++; $display("FAIL basic_entry got=%h/%0d/%h exp=1c000000/5/12345678", bus.trace_pc, bus.trace_wnum, bus.trace_wdata);
    end
    bus.trace_ready = 1'b1;
    cycle();
    idle();
    total++; if (bus.trace_valid !== 1'b0 || bus.trace_count !== 5'd0) begin
      bad++; $display("FAIL basic_pop got=%b cnt=%0d exp=0 cnt=0", bus.trace_valid, bus.trace_count);
    end
  endtask

  task automatic test_filter();
    idle();
    capture(32'h100, 4'h0, 5'd3, 32'hFFFFFFFF); cycle();
    capture(32'h104, 4'hf, 5'd0, 32'hFFFFFFFF); cycle();
    capture(32'h108, 4'b0101, 5'd7, 32'hAABBCCDD); cycle();
    idle();
    total++; if (bus.trace_count !== 5'd1) begin bad++; $display("FAIL filter_count got=%0d exp=1", bus.trace_count); end
    total++; if (bus.trace_wdata !== 32'h00BB00DD || bus.trace_pc !== 32'h108) begin
      bad++; $display("FAIL filter_mask got=%h pc=%h exp=00bb00dd pc=108", bus.trace_wdata, bus.trace_pc);
    end
    bus.trace_ready = 1'b1; cycle(); idle();
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 0; i < 20; i++) begin capture(i, 4'hf, 5'd1, $urandom); cycle(); end
    idle();
    total++; if (bus.trace_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.trace_count); end
    total++; if (bus.trace_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.trace_overflow); end
    total++; if (bus.trace_drop_cnt !== 16'd4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", bus.trace_drop_cnt); end
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.trace_pc !== 32'(i) || bus.trace_wdata !== q[0].data) begin
        bad++; $display("FAIL ovf_drain[%0d] got=%0d/%h exp=%0d/%h", i, bus.trace_pc, bus.trace_wdata, i, q[0].data);
      end
      cycle();
    end
    idle();
    total++; if (bus.trace_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", bus.trace_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] drop_before;
    do_clear();
    for (int i = 0; i < 16; i++) begin capture(i, 4'hf, 5'd2, i + 32'h50); cycle(); end
    drop_before = bus.trace_drop_cnt;
    capture(32'd99, 4'hf, 5'd2, 32'h99);
    bus.trace_ready = 1'b1;
    cycle();
    idle();
    total++; if (bus.trace_count !== 5'd16) begin bad++; $display("FAIL full_pp_count got=%0d exp=16", bus.trace_count); end
    total++; if (bus.trace_drop_cnt !== drop_before || bus.trace_overflow !== 1'b0) begin
      bad++; $display("FAIL full_pp_drop got=%0d ovf=%b exp=%0d ovf=0", bus.trace_drop_cnt, bus.trace_overflow, drop_before);
    end
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.trace_pc !== ((i == 15) ? 32'd99 : 32'(i + 1))) begin
        bad++; $display("FAIL full_pp_order[%0d] got=%0d exp=%0d", i, bus.trace_pc, (i == 15) ? 99 : i + 1);
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_stream();
    do_clear();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      capture(32'h1000 + i, 4'(1 + $urandom_range(0, 14)), 5'(1 + $urandom_range(0, 30)), $urandom);
      cycle();
      total++; if (bus.trace_valid !== 1'b1 || bus.trace_pc !== 32'h1000 + i || bus.trace_count > 5'd1
                   || bus.trace_wdata !== q[0].data || bus.trace_wnum !== q[0].wnum) begin
        bad++; $display("FAIL stream[%0d] got=%b/%h/%0d exp=1/%h/<=1", i, bus.trace_valid, bus.trace_pc, bus.trace_count, 32'h1000 + i);
      end
    end
    bus.debug_wb_rf_we = 4'h0;
    cycle();
    idle();
    total++; if (bus.trace_valid !== 1'b0 || bus.trace_drop_cnt !== 16'd0) begin
      bad++; $display("FAIL stream_end got=%b drop=%0d exp=0 drop=0", bus.trace_valid, bus.trace_drop_cnt);
    end
  endtask

  task automatic test_clear_reset();
    do_clear();
    for (int i = 0; i < 17; i++) begin capture(i, 4'hf, 5'd4, i); cycle(); end
    idle();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    idle();
    total++; if (bus.trace_count !== 5'd5 || bus.trace_overflow !== 1'b1) begin
      bad++; $display("FAIL clr_setup got=%0d ovf=%b exp=5 ovf=1", bus.trace_count, bus.trace_overflow);
    end
    capture(32'h77, 4'hf, 5'd4, 32'h77);
    bus.trace_ready = 1'b1;
    clear = 1'b1;
    cycle();
    idle();
    total++; if (bus.trace_count !== 5'd0 || bus.trace_valid !== 1'b0 || bus.trace_overflow !== 1'b0
                 || bus.trace_drop_cnt !== 16'd0) begin
      bad++; $display("FAIL clr_state got=%0d/%b/%b/%0d exp=0/0/0/0", bus.trace_count, bus.trace_valid,
                      bus.trace_overflow, bus.trace_drop_cnt);
    end
    for (int i = 0; i < 3; i++) begin capture(32'h200 + i, 4'hf, 5'd6, 32'hCAFE0000 + i); cycle(); end
    idle();
    total++; if (bus.trace_count !== 5'd3 || bus.trace_pc !== 32'h200) begin
      bad++; $display("FAIL clr_refill got=%0d pc=%h exp=3 pc=200", bus.trace_count, bus.trace_pc);
    end
    resetn = 1'b0;
    #2;
    total++; if ({bus.trace_valid, bus.trace_count, bus.trace_pc, bus.trace_wnum, bus.trace_wdata} !== 75'h0) begin
      bad++; $display("FAIL async_reset got=%b/%0d/%h/%h/%h exp=all 0", bus.trace_valid, bus.trace_count,
                      bus.trace_pc, bus.trace_wnum, bus.trace_wdata);
    end
    q.delete(); m_ov = 1'b0; m_drop = 16'h0;
    #2;
    resetn = 1'b1;
    capture(32'h300, 4'hf, 5'd9, 32'h1);
    cycle();
    idle();
    total++; if (bus.trace_count !== 5'd1 || bus.trace_pc !== 32'h300) begin
      bad++; $display("FAIL post_reset_cap got=%0d pc=%h exp=1 pc=300", bus.trace_count, bus.trace_pc);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    capture(32'h0, 4'hf, 5'd1, 32'h0);
    for (int i = 0; i < DEPTH + 65540; i++) cycle();
    idle();
    total++; if (bus.trace_drop_cnt !== 16'hFFFF || bus.trace_overflow !== 1'b1 || bus.trace_count !== 5'd16) begin
      bad++; $display("FAIL saturate got=%h ovf=%b cnt=%0d exp=ffff ovf=1 cnt=16", bus.trace_drop_cnt,
                      bus.trace_overflow, bus.trace_count);
    end
  endtask

  task automatic test_random();
    logic [91:0] got;
    logic [91:0] exp;
    do_clear();
    for (int n = 0; n < 400; n++) begin
      capture($urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), 5'($urandom_range(0, 3)), $urandom);
      bus.trace_ready = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 40) == 0);
      cycle();
      got = {bus.trace_valid, bus.trace_count, bus.trace_pc, bus.trace_wnum, bus.trace_wdata,
             bus.trace_overflow, bus.trace_drop_cnt};
      if (q.size() > 0)
        exp = {1'b1, 5'(q.size()), q[0].pc, q[0].wnum, q[0].data, m_ov, m_drop};
      else
        exp = {1'b0, 5'd0, 32'h0, 5'h0, 32'h0, m_ov, m_drop};
      total++; if (got !== exp) begin bad++; $display("FAIL random[%0d] got=%h exp=%h", n, got, exp); end
    end
    idle();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_ov   = 1'b0;
    m_drop = 16'h0;
    resetn = 1'b0;
    clear  = 1'b0;
    bus.trace_ready       = 1'b0;
    bus.debug_wb_pc       = 32'h0;
    bus.debug_wb_rf_we    = 4'h0;
    bus.debug_wb_rf_wnum  = 5'h0;
    bus.debug_wb_rf_wdata = 32'h0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    test_basic();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_stream();
    test_clear_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
